// File: rtl/axi_wr_burst_scheduler.sv
`timescale 1ns/1ps
// axi_wr_burst_scheduler
// Round-robin scheduler that shares one AXI write master among NUM_REQ
// requesters. Each grant runs one fixed 16-beat INCR burst of 32-byte beats:
// AW handshake, then 16 W beats, then the B response.
//
// Ports:
//   AXI_ACLK, AXI_ARESET_N   clock, asynchronous active-low reset
//   req_valid[r]             requester r wants one burst (sampled only in IDLE)
//   req_addr[r]              burst start address, flat NUM_REQ x ADDR_W
//   req_data[r]              current beat data, flat NUM_REQ x DATA_W
//   req_grant[r]             pulse: burst accepted for r (same cycle as decision)
//   data_pop[r]              pulse per accepted W beat; requester advances data
//   req_done[r], req_err[r]  pulse on B handshake; err = BRESP!=OKAY or BID mismatch
//   AXI_AW*, AXI_W*, AXI_B*  AXI write master channels
module axi_wr_burst_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 34,
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned ID_W    = 6
) (
  input  logic                      AXI_ACLK,
  input  logic                      AXI_ARESET_N,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_grant,
  output logic [NUM_REQ-1:0]        data_pop,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [NUM_REQ-1:0]        req_err,
  output logic [ADDR_W-1:0]         AXI_AWADDR,
  output logic [ID_W-1:0]           AXI_AWID,
  output logic [3:0]                AXI_AWLEN,
  output logic [2:0]                AXI_AWSIZE,
  output logic [1:0]                AXI_AWBURST,
  output logic                      AXI_AWVALID,
  input  logic                      AXI_AWREADY,
  output logic [DATA_W-1:0]         AXI_WDATA,
  output logic [DATA_W/8-1:0]       AXI_WSTRB,
  output logic                      AXI_WLAST,
  output logic                      AXI_WVALID,
  output logic [DATA_W/8-1:0]       AXI_WDATA_PARITY,
  input  logic                      AXI_WREADY,
  input  logic [ID_W-1:0]           AXI_BID,
  input  logic [1:0]                AXI_BRESP,
  input  logic                      AXI_BVALID,
  output logic                      AXI_BREADY
);

  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam int unsigned BYTE_N = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

  state_t            state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  grant_idx;
  logic [ADDR_W-1:0] addr_reg;
  logic [3:0]        beat_cnt;
  logic              awvalid;
  logic              wvalid;
  logic              wlast;
  logic              bready;

  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic [IDX_W-1:0]  cand_idx;
  logic [NUM_REQ-1:0] one_hot_base;

  assign one_hot_base = {{(NUM_REQ-1){1'b0}}, 1'b1};

  // Round-robin search: first asserted request at or after rr_ptr, with wrap.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand_idx = IDX_W'((32'(rr_ptr) + i) % NUM_REQ);
      if (!sel_found && req_valid[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  // Burst sequencer: IDLE -> AW -> W -> B -> IDLE with registered channel controls.
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESET_N) begin
    if (!AXI_ARESET_N) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      addr_reg  <= '0;
      beat_cnt  <= '0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      wlast     <= 1'b0;
      bready    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sel_found) begin
            grant_idx <= sel_idx;
            addr_reg  <= req_addr[32'(sel_idx)*ADDR_W +: ADDR_W];
            rr_ptr    <= IDX_W'((32'(sel_idx) + 32'd1) % NUM_REQ);
            awvalid   <= 1'b1;
            state     <= S_AW;
          end
        end
        S_AW: begin
          if (AXI_AWREADY) begin
            awvalid  <= 1'b0;
            wvalid   <= 1'b1;
            wlast    <= 1'b0;
            beat_cnt <= '0;
            state    <= S_W;
          end
        end
        S_W: begin
          if (AXI_WREADY) begin
            // 4-bit counter wraps to 0 exactly on the last beat.
            beat_cnt <= beat_cnt + 4'd1;
            wlast    <= (beat_cnt == 4'd14);
            if (beat_cnt == 4'd15) begin
              wvalid <= 1'b0;
              wlast  <= 1'b0;
              bready <= 1'b1;
              state  <= S_B;
            end
          end
        end
        S_B: begin
          if (AXI_BVALID) begin
            bready <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Same-cycle requester strobes; grant is suppressed while reset is asserted.
  always_comb begin
    req_grant = '0;
    data_pop  = '0;
    req_done  = '0;
    req_err   = '0;
    if (state == S_IDLE && sel_found && AXI_ARESET_N) begin
      req_grant = one_hot_base << sel_idx;
    end
    if (state == S_W && AXI_WREADY) begin
      data_pop = one_hot_base << grant_idx;
    end
    if (state == S_B && AXI_BVALID) begin
      req_done = one_hot_base << grant_idx;
      if (AXI_BRESP != 2'b00 || AXI_BID != ID_W'(grant_idx)) begin
        req_err = one_hot_base << grant_idx;
      end
    end
  end

  // Byte-wise even parity of the outgoing beat.
  always_comb begin
    AXI_WDATA_PARITY = '0;
    for (int unsigned k = 0; k < BYTE_N; k++) begin
      AXI_WDATA_PARITY[k] = ^AXI_WDATA[8*k +: 8];
    end
  end

  assign AXI_AWADDR  = addr_reg;
  assign AXI_AWID    = ID_W'(grant_idx);
  assign AXI_AWLEN   = 4'd15;
  assign AXI_AWSIZE  = 3'd5;
  assign AXI_AWBURST = 2'b01;
  assign AXI_AWVALID = awvalid;
  assign AXI_WDATA   = req_data[32'(grant_idx)*DATA_W +: DATA_W];
  assign AXI_WSTRB   = '1;
  assign AXI_WLAST   = wlast;
  assign AXI_WVALID  = wvalid;
  assign AXI_BREADY  = bready;

endmodule

// File: tb/tb_axi_wr_burst_scheduler.sv
`timescale 1ns/1ps
// Bench for axi_wr_burst_scheduler: randomized requesters and AXI slave,
// a transaction-level reference model that predicts grants, beats and
// responses from the stimulus alone, and a scoreboard monitor.
module tb_axi_wr_burst_scheduler;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ADDR_W  = 34;
  localparam int unsigned DATA_W  = 256;
  localparam int unsigned ID_W    = 6;

  typedef struct packed { logic [ADDR_W-1:0] addr; logic [7:0] idx; } aw_t;
  typedef struct packed { logic [DATA_W-1:0] data; logic last; } beat_t;
  typedef struct packed { logic [7:0] idx; logic err; } done_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_grant, data_pop, req_done, req_err;
  logic [ADDR_W-1:0]         AXI_AWADDR;
  logic [ID_W-1:0]           AXI_AWID;
  logic [3:0]                AXI_AWLEN;
  logic [2:0]                AXI_AWSIZE;
  logic [1:0]                AXI_AWBURST;
  logic                      AXI_AWVALID, AXI_AWREADY;
  logic [DATA_W-1:0]         AXI_WDATA;
  logic [31:0]               AXI_WSTRB, AXI_WDATA_PARITY;
  logic                      AXI_WLAST, AXI_WVALID, AXI_WREADY;
  logic [ID_W-1:0]           AXI_BID;
  logic [1:0]                AXI_BRESP;
  logic                      AXI_BVALID, AXI_BREADY;

  axi_wr_burst_scheduler #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .AXI_ACLK(clk), .AXI_ARESET_N(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_grant(req_grant), .data_pop(data_pop), .req_done(req_done), .req_err(req_err),
    .AXI_AWADDR(AXI_AWADDR), .AXI_AWID(AXI_AWID), .AXI_AWLEN(AXI_AWLEN), .AXI_AWSIZE(AXI_AWSIZE),
    .AXI_AWBURST(AXI_AWBURST), .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
    .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_WLAST(AXI_WLAST), .AXI_WVALID(AXI_WVALID),
    .AXI_WDATA_PARITY(AXI_WDATA_PARITY), .AXI_WREADY(AXI_WREADY),
    .AXI_BID(AXI_BID), .AXI_BRESP(AXI_BRESP), .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY)
  );

  initial forever #5 clk = ~clk;

  // Bookkeeping
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W/32; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [31:0] byte_parity(input logic [DATA_W-1:0] d);
    logic [31:0] p;
    for (int k = 0; k < 32; k++) p[k] = ^d[8*k +: 8];
    return p;
  endfunction

  // Round-robin rule: first valid index at or after ptr, wrapping.
  function automatic int rr_pick(input int ptr, input logic [NUM_REQ-1:0] v);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (v[(ptr + i) % NUM_REQ]) return (ptr + i) % NUM_REQ;
    end
    return -1;
  endfunction

  // Requester-side state and stimulus knobs
  logic [ADDR_W-1:0] addr_a [NUM_REQ];
  logic [DATA_W-1:0] data_a [NUM_REQ];
  logic [NUM_REQ-1:0] pop_flag = '0;
  logic [NUM_REQ-1:0] req_mask = '0;
  int req_pct = 100, aw_pct = 100, w_pct = 100, b_pct = 100;
  int aw_hold = 0, force_bresp = -1, force_bid = -1;
  bit w_toggle = 0, w_tog = 0, byte0_mode = 0, fixed_addr_en = 0;
  logic [ADDR_W-1:0] fixed_addr = '0;

  always_comb begin
    for (int r = 0; r < NUM_REQ; r++) begin
      req_addr[r*ADDR_W +: ADDR_W] = addr_a[r];
      req_data[r*DATA_W +: DATA_W] = data_a[r];
    end
  end

  // Reference model state
  int m_phase = 0;  // 0 idle, 1 address, 2 data, 3 response
  int m_ptr = 0, m_idx = 0, m_beat = 0, m_aw_wait = 0, m_done_cnt = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  aw_t   aw_q[$];
  beat_t beat_q[$];
  done_t done_q[$];

  // Monitor observations
  int grant_log[$];
  int pop_cnt [NUM_REQ];
  int wlast_cnt = 0;
  logic last_err = 1'b0;
  int last_done_idx = -1;
  logic [31:0] last_parity = '0;

  // Stimulus driver: inputs change 1 time unit after the rising edge.
  initial begin
    req_valid = '0;
    AXI_AWREADY = 1'b0; AXI_WREADY = 1'b0; AXI_BVALID = 1'b0; AXI_BRESP = '0; AXI_BID = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      addr_a[r] = '0;
      data_a[r] = rand_data();
      pop_cnt[r] = 0;
    end
    forever begin
      @(posedge clk); #1;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (byte0_mode) data_a[r] = DATA_W'(1);
        else if (pop_flag[r]) data_a[r] = rand_data();
        pop_flag[r] = 1'b0;
        req_valid[r] = req_mask[r] && ($urandom_range(99) < 32'(req_pct));
        addr_a[r] = fixed_addr_en ? fixed_addr : ADDR_W'({$urandom, $urandom});
      end
      AXI_AWREADY = (m_phase == 1 && m_aw_wait < aw_hold) ? 1'b0 : ($urandom_range(99) < 32'(aw_pct));
      if (m_phase == 2) w_tog = ~w_tog; else w_tog = 1'b0;
      AXI_WREADY = w_toggle ? w_tog : ($urandom_range(99) < 32'(w_pct));
      if (m_phase == 3 && $urandom_range(99) < 32'(b_pct)) begin
        AXI_BVALID = 1'b1;
        AXI_BRESP = (force_bresp >= 0) ? 2'(force_bresp)
                  : (($urandom_range(9) == 0) ? 2'($urandom_range(3)) : 2'b00);
        AXI_BID   = (force_bid >= 0) ? ID_W'(force_bid)
                  : (($urandom_range(9) == 0) ? ID_W'($urandom) : ID_W'(m_idx));
      end else begin
        AXI_BVALID = 1'b0; AXI_BRESP = '0; AXI_BID = '0;
      end
    end
  end

  // Reference model: predicts this cycle's outputs from the stimulus only.
  initial begin
    forever begin
      logic [NUM_REQ-1:0] e_grant, e_pop, e_done, e_err;
      int pk;
      @(negedge clk);
      e_grant = '0; e_pop = '0; e_done = '0; e_err = '0;
      if (!rst_n) begin
        m_phase = 0; m_ptr = 0; m_beat = 0; m_aw_wait = 0;
        aw_q.delete(); beat_q.delete(); done_q.delete();
        chk("rst_awvalid", AXI_AWVALID, 0);
        chk("rst_wvalid", AXI_WVALID, 0);
        chk("rst_wlast", AXI_WLAST, 0);
        chk("rst_bready", AXI_BREADY, 0);
        chk("rst_awaddr", AXI_AWADDR, 0);
        chk("rst_awid", AXI_AWID, 0);
        chk("rst_strobes", {req_grant, data_pop, req_done, req_err}, 0);
      end else begin
        chk("awvalid", AXI_AWVALID, m_phase == 1);
        chk("wvalid", AXI_WVALID, m_phase == 2);
        chk("bready", AXI_BREADY, m_phase == 3);
        case (m_phase)
          0: begin
            pk = rr_pick(m_ptr, req_valid);
            if (pk >= 0) begin
              e_grant[pk] = 1'b1;
              m_idx = pk;
              m_addr = addr_a[pk];
              aw_q.push_back('{addr: m_addr, idx: 8'(pk)});
              m_ptr = (pk + 1) % NUM_REQ;
              m_phase = 1;
              m_aw_wait = 0;
            end
          end
          1: begin
            chk("awaddr_hold", AXI_AWADDR, m_addr);
            chk("awid_hold", AXI_AWID, m_idx);
            if (AXI_AWREADY) begin m_phase = 2; m_beat = 0; end
            else m_aw_wait++;
          end
          2: begin
            chk("wdata_hold", AXI_WDATA, data_a[m_idx]);
            chk("wlast_level", AXI_WLAST, m_beat == 15);
            if (AXI_WREADY) begin
              e_pop[m_idx] = 1'b1;
              beat_q.push_back('{data: data_a[m_idx], last: (m_beat == 15)});
              pop_flag[m_idx] = 1'b1;
              m_beat++;
              if (m_beat == 16) m_phase = 3;
            end
          end
          default: begin
            if (AXI_BVALID) begin
              e_done[m_idx] = 1'b1;
              e_err[m_idx] = (AXI_BRESP != 2'b00) || (int'(AXI_BID) != m_idx);
              done_q.push_back('{idx: 8'(m_idx), err: e_err[m_idx]});
              m_phase = 0;
              m_done_cnt++;
            end
          end
        endcase
        chk("grant_vec", req_grant, e_grant);
        chk("pop_vec", data_pop, e_pop);
        chk("done_vec", req_done, e_done);
        chk("err_vec", req_err, e_err);
      end
    end
  end

  // Scoreboard monitor: pops expectations whenever the DUT presents a transfer.
  initial begin
    forever begin
      aw_t a; beat_t b; done_t d;
      logic [NUM_REQ-1:0] oh;
      @(negedge clk); #2;
      if (rst_n) begin
        for (int i = 0; i < NUM_REQ; i++) if (req_grant[i]) grant_log.push_back(i);
        if (AXI_AWVALID && AXI_AWREADY) begin
          if (aw_q.size() == 0) chk("aw_unexpected", 1, 0);
          else begin
            a = aw_q.pop_front();
            chk("aw_addr", AXI_AWADDR, a.addr);
            chk("aw_id", AXI_AWID, a.idx);
            chk("aw_len", AXI_AWLEN, 15);
            chk("aw_size", AXI_AWSIZE, 5);
            chk("aw_burst", AXI_AWBURST, 1);
          end
        end
        if (AXI_WVALID && AXI_WREADY) begin
          if (beat_q.size() == 0) chk("w_unexpected", 1, 0);
          else begin
            b = beat_q.pop_front();
            chk("w_data", AXI_WDATA, b.data);
            chk("w_last", AXI_WLAST, b.last);
            chk("w_parity", AXI_WDATA_PARITY, byte_parity(b.data));
            chk("w_strb", AXI_WSTRB, 32'hffff_ffff);
          end
          for (int i = 0; i < NUM_REQ; i++) if (data_pop[i]) pop_cnt[i]++;
          if (AXI_WLAST) wlast_cnt++;
          last_parity = AXI_WDATA_PARITY;
        end
        if (|req_done) begin
          if (done_q.size() == 0) chk("done_unexpected", 1, 0);
          else begin
            d = done_q.pop_front();
            oh = '0;
            oh[d.idx] = 1'b1;
            chk("b_done", req_done, oh);
            chk("b_err", req_err, d.err ? oh : '0);
            last_err = d.err;
            last_done_idx = int'(d.idx);
          end
        end
      end
    end
  end

  task automatic wait_done(input int n);
    int target;
    target = m_done_cnt + n;
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk); #1;
      if (m_done_cnt >= target) return;
    end
    chk("timeout_bursts", m_done_cnt, target);
  endtask

  task automatic do_reset();
    req_mask = '0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_pct = 100; aw_pct = 100; w_pct = 100; b_pct = 100;
    aw_hold = 0; force_bresp = -1; force_bid = -1;
    w_toggle = 0; byte0_mode = 0; fixed_addr_en = 0;
  endtask

  initial begin
    int p0, l0;
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single requester 2 at a 33-bit address, slave always ready
    fixed_addr_en = 1; fixed_addr = 34'h1_0000_0000;
    grant_log.delete();
    p0 = pop_cnt[2]; l0 = wlast_cnt;
    req_mask = 4'b0100;
    wait_done(1);
    chk("t1_pops", pop_cnt[2] - p0, 16);
    chk("t1_wlast", wlast_cnt - l0, 1);
    chk("t1_err", last_err, 0);
    chk("t1_done_idx", last_done_idx, 2);
    chk("t1_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 2);
    do_reset();

    // All requesters continuously active: strict rotation
    grant_log.delete();
    req_mask = 4'b1111;
    wait_done(5);
    chk("t2_len", grant_log.size() >= 5, 1);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) chk("t2_order", grant_log[i], exp_order[i]);
    do_reset();

    // AWREADY held off 5 cycles, WREADY toggling
    aw_hold = 5; w_toggle = 1;
    p0 = pop_cnt[0];
    req_mask = 4'b0001;
    wait_done(1);
    chk("t3_pops", pop_cnt[0] - p0, 16);
    do_reset();

    // Error responses for requester 1
    force_bresp = 2;
    req_mask = 4'b0010;
    wait_done(1);
    chk("t4_bresp_err", last_err, 1);
    chk("t4_done_idx", last_done_idx, 1);
    force_bresp = 0; force_bid = 3;
    wait_done(1);
    chk("t4_bid_err", last_err, 1);
    do_reset();

    // Parity with only byte 0 = 0x01
    byte0_mode = 1;
    req_mask = 4'b0001;
    wait_done(1);
    chk("t5_parity", last_parity, 32'h0000_0001);
    do_reset();

    // Randomized traffic with back-pressure and occasional error responses
    req_pct = 40; aw_pct = 60; w_pct = 60; b_pct = 50;
    req_mask = 4'b1111;
    wait_done(40);
    do_reset();

    // Reset after beat 7 of a burst
    req_mask = 4'b1111;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      if (m_phase == 2 && m_beat >= 7) break;
    end
    chk("t6_reached_beat7", (m_phase == 2 && m_beat >= 7), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_awvalid_drop", AXI_AWVALID, 0);
    chk("t6_wvalid_drop", AXI_WVALID, 0);
    chk("t6_bready_drop", AXI_BREADY, 0);
    repeat (2) @(posedge clk);
    #1;
    grant_log.delete();
    rst_n = 1'b1;
    wait_done(1);
    chk("t6_first_after_reset", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
    do_reset();

    repeat (3) @(posedge clk);
    chk("aw_q_drained", aw_q.size(), 0);
    chk("beat_q_drained", beat_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
